// File: rtl/result_writeback_buffer_pkg.sv
// Shared result-entry type and tag/sequence-number age helpers.
// Optional single-cycle bypass is enabled by defining RESULT_BYPASS_EN.
package result_writeback_buffer_pkg;

    localparam int DATA_W = 32;
    localparam int TAG_W  = 6;
    localparam int SQN_W  = 6;
    localparam int NM_W   = 5;

    typedef struct packed {
        logic              valid;
        logic [DATA_W-1:0] result;
        logic [TAG_W-1:0]  tagDst;
        logic [NM_W-1:0]   nmDst;
        logic [SQN_W-1:0]  sqN;
    } ResultEntry;

    // Wrap-around age: a is older when (a - b) is negative in SQN_W bits.
    function automatic logic is_older(
        input logic [SQN_W-1:0] a,
        input logic [SQN_W-1:0] b
    );
        logic [SQN_W-1:0] d;
        d = a - b;
        return d[SQN_W-1];
    endfunction

    function automatic logic is_younger_tag(
        input logic [TAG_W-1:0] t,
        input logic [TAG_W-1:0] bound
    );
        logic [TAG_W-1:0] d;
        d = t - bound;
        return !d[TAG_W-1] && (d != '0);
    endfunction

endpackage

// File: rtl/result_writeback_buffer_oldest_select.sv
// Finds the oldest valid, non-excluded entry; ties go to the lower index.
module result_writeback_buffer_oldest_select
    import result_writeback_buffer_pkg::*;
#(
    parameter int N  = 4,
    parameter int IW = 2
) (
    input  ResultEntry [N-1:0] entries_i,
    input  logic [N-1:0]       excl_i,
    output logic               found_o,
    output logic [IW-1:0]      idx_o
);

    logic          hit;
    logic [IW-1:0] best;
    logic          unused_fields;

    assign unused_fields = ^entries_i;

    always_comb begin
        hit  = 1'b0;
        best = '0;
        for (int i = 0; i < N; i++) begin
            if (entries_i[i].valid && !excl_i[i] &&
                (!hit || is_older(entries_i[i].sqN,
                                  entries_i[best].sqN))) begin
                hit  = 1'b1;
                best = IW'(i);
            end
        end
    end

    assign found_o = hit;
    assign idx_o   = best;

endmodule

// File: rtl/result_writeback_buffer.sv
// Unordered result slots broadcast oldest-first onto the result buses.
// Define RESULT_BYPASS_EN to let results skip an empty buffer.
module result_writeback_buffer
    import result_writeback_buffer_pkg::*;
#(
    parameter int NUM_SRC          = 2,
    parameter int BUF_SIZE         = 4,
    parameter int RESULT_BUS_COUNT = 1
) (
    input  logic                                   clk,
    input  logic                                   rst,
    input  logic [NUM_SRC-1:0]                     IN_valid,
    input  logic [NUM_SRC-1:0][DATA_W-1:0]         IN_result,
    input  logic [NUM_SRC-1:0][TAG_W-1:0]          IN_tagDst,
    input  logic [NUM_SRC-1:0][NM_W-1:0]           IN_nmDst,
    input  logic [NUM_SRC-1:0][SQN_W-1:0]          IN_sqN,
    output logic [NUM_SRC-1:0]                     OUT_ready,
    input  logic                                   IN_invalidate,
    input  logic [TAG_W-1:0]                       IN_invalidateTag,
    output logic [RESULT_BUS_COUNT-1:0]            OUT_resultValid,
    output logic [RESULT_BUS_COUNT-1:0][DATA_W-1:0] OUT_resultBus,
    output logic [RESULT_BUS_COUNT-1:0][TAG_W-1:0] OUT_resultTag,
    output logic [RESULT_BUS_COUNT-1:0][NM_W-1:0]  OUT_resultNmDst,
    output logic [RESULT_BUS_COUNT-1:0][SQN_W-1:0] OUT_resultSqN
);

    localparam int IW = (BUF_SIZE > 1) ? $clog2(BUF_SIZE) : 1;
    localparam int RB = RESULT_BUS_COUNT;

    ResultEntry [BUF_SIZE-1:0] slots_q, slots_d;
    ResultEntry [RB-1:0]       bus_q, bus_d;
    ResultEntry [NUM_SRC-1:0]  in_ent;

    logic [NUM_SRC-1:0]          accept;
    logic [RB-1:0][BUF_SIZE-1:0] excl;
    logic [RB-1:0]               sel_found;
    logic [RB-1:0][IW-1:0]       sel_idx;
    int                          free_cnt;

    // Ready looks only at slots free at the start of the cycle.
    always_comb begin
        free_cnt = 0;
        for (int s = 0; s < BUF_SIZE; s++) begin
            if (!slots_q[s].valid) free_cnt++;
        end
        for (int i = 0; i < NUM_SRC; i++) begin
            OUT_ready[i] = rst && !IN_invalidate && (free_cnt > i);
            in_ent[i] = '{valid:  1'b1,
                          result: IN_result[i],
                          tagDst: IN_tagDst[i],
                          nmDst:  IN_nmDst[i],
                          sqN:    IN_sqN[i]};
        end
    end

    assign accept = IN_valid & OUT_ready;

    for (genvar b = 0; b < RB; b++) begin : g_sel
        if (b == 0) begin : g_first
            assign excl[b] = '0;
        end else begin : g_next
            assign excl[b] = excl[b-1] |
                (sel_found[b-1] ? (BUF_SIZE'(1) << sel_idx[b-1]) : '0);
        end
        result_writeback_buffer_oldest_select #(
            .N  (BUF_SIZE),
            .IW (IW)
        ) u_sel (
            .entries_i (slots_q),
            .excl_i    (excl[b]),
            .found_o   (sel_found[b]),
            .idx_o     (sel_idx[b])
        );
    end

    always_comb begin
        logic                placed;
        logic [BUF_SIZE-1:0] claimed;
        logic [NUM_SRC-1:0]  byp;
`ifdef RESULT_BYPASS_EN
        logic hit;
        int   best;
        hit  = 1'b0;
        best = 0;
`endif
        placed  = 1'b0;
        claimed = '0;
        byp     = '0;
        slots_d = slots_q;
        bus_d   = bus_q;
        for (int b = 0; b < RB; b++) bus_d[b].valid = 1'b0;
        if (IN_invalidate) begin
            for (int s = 0; s < BUF_SIZE; s++) begin
                if (is_younger_tag(slots_q[s].tagDst, IN_invalidateTag))
                    slots_d[s].valid = 1'b0;
            end
        end else begin
            for (int b = 0; b < RB; b++) begin
                if (sel_found[b]) begin
                    bus_d[b] = slots_q[sel_idx[b]];
                    slots_d[sel_idx[b]].valid = 1'b0;
                end
            end
`ifdef RESULT_BYPASS_EN
            if (free_cnt == BUF_SIZE) begin
                for (int b = 0; b < RB; b++) begin
                    hit  = 1'b0;
                    best = 0;
                    for (int i = 0; i < NUM_SRC; i++) begin
                        if (accept[i] && !byp[i] &&
                            (!hit || is_older(in_ent[i].sqN,
                                              in_ent[best].sqN))) begin
                            hit  = 1'b1;
                            best = i;
                        end
                    end
                    if (hit) begin
                        byp[best] = 1'b1;
                        bus_d[b]  = in_ent[best];
                    end
                end
            end
`endif
            for (int i = 0; i < NUM_SRC; i++) begin
                if (accept[i] && !byp[i]) begin
                    placed = 1'b0;
                    for (int s = 0; s < BUF_SIZE; s++) begin
                        if (!placed && !slots_q[s].valid && !claimed[s]) begin
                            placed     = 1'b1;
                            claimed[s] = 1'b1;
                            slots_d[s] = in_ent[i];
                        end
                    end
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            slots_q <= '0;
            bus_q   <= '0;
        end else begin
            slots_q <= slots_d;
            bus_q   <= bus_d;
        end
    end

    always_comb begin
        for (int b = 0; b < RB; b++) begin
            OUT_resultValid[b] = bus_q[b].valid;
            OUT_resultBus[b]   = bus_q[b].result;
            OUT_resultTag[b]   = bus_q[b].tagDst;
            OUT_resultNmDst[b] = bus_q[b].nmDst;
            OUT_resultSqN[b]   = bus_q[b].sqN;
        end
    end

endmodule

// File: tb/tb_result_writeback_buffer.sv
// Directed and random checks of the result writeback buffer
// against a queue-based model of the buffered results.
module tb_result_writeback_buffer;

    logic             clk = 1'b0;
    logic             rst;
    logic [1:0]       IN_valid;
    logic [1:0][31:0] IN_result;
    logic [1:0][5:0]  IN_tagDst;
    logic [1:0][4:0]  IN_nmDst;
    logic [1:0][5:0]  IN_sqN;
    logic [1:0]       OUT_ready;
    logic             IN_invalidate;
    logic [5:0]       IN_invalidateTag;
    logic [0:0]       OUT_resultValid;
    logic [0:0][31:0] OUT_resultBus;
    logic [0:0][5:0]  OUT_resultTag;
    logic [0:0][4:0]  OUT_resultNmDst;
    logic [0:0][5:0]  OUT_resultSqN;

    result_writeback_buffer #(
        .NUM_SRC          (2),
        .BUF_SIZE         (4),
        .RESULT_BUS_COUNT (1)
    ) dut (
        .clk              (clk),
        .rst              (rst),
        .IN_valid         (IN_valid),
        .IN_result        (IN_result),
        .IN_tagDst        (IN_tagDst),
        .IN_nmDst         (IN_nmDst),
        .IN_sqN           (IN_sqN),
        .OUT_ready        (OUT_ready),
        .IN_invalidate    (IN_invalidate),
        .IN_invalidateTag (IN_invalidateTag),
        .OUT_resultValid  (OUT_resultValid),
        .OUT_resultBus    (OUT_resultBus),
        .OUT_resultTag    (OUT_resultTag),
        .OUT_resultNmDst  (OUT_resultNmDst),
        .OUT_resultSqN    (OUT_resultSqN)
    );

    always #5 clk = ~clk;

    typedef struct {
        int res;
        int tag;
        int nm;
        int sqn;
    } item_t;

    item_t mq[$];
    item_t last;
    int    n_checks = 0;
    int    n_fail   = 0;

    function automatic int mod64(input int x);
        return ((x % 64) + 64) % 64;
    endfunction

    function automatic bit m_older(input int a, input int b);
        return mod64(a - b) >= 32;
    endfunction

    function automatic bit m_younger(input int t, input int bound);
        int d;
        d = mod64(t - bound);
        return (d > 0) && (d < 32);
    endfunction

    task automatic chk(input string tag, input int obs, input int exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic set_in(input int p, input int res, input int tag,
                          input int nm, input int sqn);
        IN_result[p] = 32'(res);
        IN_tagDst[p] = 6'(tag);
        IN_nmDst[p]  = 5'(nm);
        IN_sqN[p]    = 6'(sqn);
    endtask

    // Called just after a falling edge; returns just after the next one.
    task automatic tick(input logic [1:0] v, input logic inv,
                        input int itag, input logic r);
        int    fr;
        int    k;
        bit    ev;
        bit    er[2];
        item_t it;
        rst              = r;
        IN_valid         = v;
        IN_invalidate    = inv;
        IN_invalidateTag = 6'(itag);
        #1;
        fr = 4 - mq.size();
        for (int p = 0; p < 2; p++) begin
            er[p] = r && !inv && (fr >= p + 1);
            chk($sformatf("ready%0d", p), int'(OUT_ready[p]), int'(er[p]));
        end
        ev = 1'b0;
        if (!r) begin
            mq.delete();
            last = '{0, 0, 0, 0};
        end else if (inv) begin
            for (int j = mq.size() - 1; j >= 0; j--) begin
                if (m_younger(mq[j].tag, itag)) mq.delete(j);
            end
        end else begin
            if (mq.size() > 0) begin
                k = 0;
                for (int j = 1; j < mq.size(); j++) begin
                    if (m_older(mq[j].sqn, mq[k].sqn)) k = j;
                end
                last = mq[k];
                ev   = 1'b1;
                mq.delete(k);
            end
            for (int p = 0; p < 2; p++) begin
                if (v[p] && er[p]) begin
                    it.res = int'(IN_result[p]);
                    it.tag = int'(IN_tagDst[p]);
                    it.nm  = int'(IN_nmDst[p]);
                    it.sqn = int'(IN_sqN[p]);
                    mq.push_back(it);
                end
            end
        end
        @(posedge clk);
        @(negedge clk);
        chk("bus_valid", int'(OUT_resultValid[0]), int'(ev));
        chk("bus_data", int'(OUT_resultBus[0]), last.res);
        chk("bus_tag", int'(OUT_resultTag[0]), last.tag);
        chk("bus_nm", int'(OUT_resultNmDst[0]), last.nm);
        chk("bus_sqn", int'(OUT_resultSqN[0]), last.sqn);
    endtask

    task automatic idle(input int n);
        for (int c = 0; c < n; c++) tick(2'b00, 1'b0, 0, 1'b1);
    endtask

    initial begin
        logic [5:0] seq;
        int         gap;
        logic [1:0] rv;
        logic       rinv;
        last             = '{0, 0, 0, 0};
        rst              = 1'b0;
        IN_valid         = '0;
        IN_invalidate    = 1'b0;
        IN_invalidateTag = '0;
        IN_result        = '0;
        IN_tagDst        = '0;
        IN_nmDst         = '0;
        IN_sqN           = '0;
        @(negedge clk);
        tick(2'b11, 1'b0, 0, 1'b0);
        tick(2'b00, 1'b0, 0, 1'b0);
        idle(1);

        // single result, two-cycle latency
        set_in(0, 32'hDEADBEEF, 5, 3, 3);
        tick(2'b01, 1'b0, 0, 1'b1);
        idle(4);

        // age order within one cycle
        set_in(0, 32'h0000_0007, 7, 7, 7);
        set_in(1, 32'h0000_000A, 10, 10, 10);
        tick(2'b11, 1'b0, 0, 1'b1);
        idle(4);

        // sequence-number wrap-around
        set_in(0, 32'h1111_0001, 11, 1, 1);
        set_in(1, 32'h2222_003E, 12, 2, 62);
        tick(2'b11, 1'b0, 0, 1'b1);
        idle(4);

        // sustained offers on both ports: port 1 backpressured
        for (int c = 0; c < 4; c++) begin
            set_in(0, 32'hA000_0000 + c, 20 + c, c, 14 + 2 * c);
            set_in(1, 32'hB000_0000 + c, 30 + c, c, 15 + 2 * c);
            tick(2'b11, 1'b0, 0, 1'b1);
        end
        idle(6);

        // flush of tags younger than 4
        set_in(0, 32'hF11E_0001, 1, 1, 30);
        set_in(1, 32'hC0DE_0002, 2, 2, 31);
        tick(2'b11, 1'b0, 0, 1'b1);
        set_in(0, 32'hC0DE_0004, 4, 4, 32);
        set_in(1, 32'hC0DE_0006, 6, 6, 33);
        tick(2'b11, 1'b0, 0, 1'b1);
        tick(2'b00, 1'b1, 4, 1'b1);
        idle(4);

        // reset while three slots hold results
        set_in(0, 32'h5555_0032, 50, 1, 50);
        set_in(1, 32'h5555_0033, 51, 2, 51);
        tick(2'b11, 1'b0, 0, 1'b1);
        set_in(0, 32'h5555_0034, 52, 3, 52);
        set_in(1, 32'h5555_0035, 53, 4, 53);
        tick(2'b11, 1'b0, 0, 1'b1);
        tick(2'b11, 1'b0, 0, 1'b0);
        idle(4);

        // random traffic with occasional flushes
        seq = 6'd40;
        gap = 0;
        for (int c = 0; c < 400; c++) begin
            rv   = 2'($urandom_range(0, 3));
            rinv = (gap > 8) && ($urandom_range(0, 9) == 0);
            gap  = rinv ? 0 : gap + 1;
            for (int p = 0; p < 2; p++) begin
                set_in(p, int'($urandom), int'(6'($urandom)),
                       int'(5'($urandom)), 0);
            end
            if ($urandom_range(0, 1) == 1) begin
                IN_sqN[0] = seq;
                IN_sqN[1] = seq + 6'd1;
            end else begin
                IN_sqN[0] = seq + 6'd1;
                IN_sqN[1] = seq;
            end
            seq = seq + 6'd2;
            tick(rv, rinv, int'(6'($urandom)), 1'b1);
        end
        idle(6);

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_checks, n_fail);
        $finish;
    end

endmodule
